// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: register-file write port,
// one-cycle commit bypass toward decode, and a retired-instruction counter.
module mem_wb_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mem_valid,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [REG_ADDR_WIDTH-1:0] exeMuxRes_out,
   input  logic [DATA_WIDTH-1:0]     ReadData,
   input  logic [DATA_WIDTH-1:0]     ALUResult,
   input  logic                      RegWrite_out,
   input  logic                      MemtoReg_out,
   output logic                      wb_valid,
   output logic [REG_ADDR_WIDTH-1:0] WriteReg,
   output logic [DATA_WIDTH-1:0]     WriteData,
   output logic                      RegWrite_wb,
   output logic                      prev_RegWrite,
   output logic [REG_ADDR_WIDTH-1:0] prev_WriteReg,
   output logic [DATA_WIDTH-1:0]     prev_WriteData,
   output logic [CNT_WIDTH-1:0]      retired_count
);

   logic                      validQ;
   logic                      newQ;
   logic [REG_ADDR_WIDTH-1:0] destQ;
   logic [DATA_WIDTH-1:0]     rdataQ;
   logic [DATA_WIDTH-1:0]     aluQ;
   logic                      regwriteQ;
   logic                      memtoregQ;

   logic                      doLoad;

   // A load happens only when neither flush nor stall claims the edge.
   assign doLoad = !flush && !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         validQ    <= 1'b0;
         newQ      <= 1'b0;
         destQ     <= '0;
         rdataQ    <= '0;
         aluQ      <= '0;
         regwriteQ <= 1'b0;
         memtoregQ <= 1'b0;
      end else if (flush) begin
         validQ    <= 1'b0;
         newQ      <= 1'b0;
         regwriteQ <= 1'b0;
      end else if (stall) begin
         // Held entry has already committed; clearing newQ blocks a second write.
         newQ      <= 1'b0;
      end else begin
         validQ    <= mem_valid;
         newQ      <= mem_valid;
         destQ     <= exeMuxRes_out;
         rdataQ    <= ReadData;
         aluQ      <= ALUResult;
         regwriteQ <= RegWrite_out;
         memtoregQ <= MemtoReg_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_count <= '0;
      end else if (doLoad && mem_valid) begin
         retired_count <= retired_count + CNT_WIDTH'(1);
      end
   end

   assign wb_valid    = validQ;
   assign WriteReg    = destQ;
   assign WriteData   = memtoregQ ? rdataQ : aluQ;
   assign RegWrite_wb = validQ && newQ && regwriteQ && (destQ != '0);

   // Bypass register updates every edge regardless of stall/flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_RegWrite  <= 1'b0;
         prev_WriteReg  <= '0;
         prev_WriteData <= '0;
      end else begin
         prev_RegWrite  <= RegWrite_wb;
         prev_WriteReg  <= WriteReg;
         prev_WriteData <= WriteData;
      end
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback stage of the MIPS pipeline. It sits directly downstream of `memory_module` and captures its outputs (destination register, load data, ALU result, RegWrite/MemtoReg). It drives the register-file write port and a one-cycle commit bypass toward decode, and counts retired instructions. It supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
Parameters:
- DATA_WIDTH, 32, width of ReadData/ALUResult/WriteData
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 32, retired-instruction counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM stage holds a valid instruction
- stall  in  1  hold MEM/WB contents this edge
- flush  in  1  load a bubble this edge
- exeMuxRes_out  in  REG_ADDR_WIDTH  destination register from MEM
- ReadData  in  DATA_WIDTH  data-memory read data
- ALUResult  in  DATA_WIDTH  ALU result passed through MEM
- RegWrite_out  in  1  instruction writes a register
- MemtoReg_out  in  1  1 = write ReadData, 0 = write ALUResult
- wb_valid  out  1  WB holds a valid instruction
- WriteReg  out  REG_ADDR_WIDTH  register-file write index
- WriteData  out  DATA_WIDTH  register-file write data
- RegWrite_wb  out  1  register-file write enable
- prev_RegWrite  out  1  previous-cycle commit valid (bypass)
- prev_WriteReg  out  REG_ADDR_WIDTH  previous-cycle commit index
- prev_WriteData  out  DATA_WIDTH  previous-cycle commit data
- retired_count  out  CNT_WIDTH  instructions loaded into WB, wraps

## Operation
- Registered fields: valid_q, new_q, dest_q, rdata_q, alu_q, regwrite_q, memtoreg_q.
- Edge priority: flush > stall > load.
  - flush: valid_q←0, new_q←0, regwrite_q←0; data fields don't-care (implemented as hold).
  - stall (no flush): all fields hold; new_q←0.
  - otherwise: capture all inputs; valid_q←mem_valid; new_q←mem_valid.
- WriteData = memtoreg_q ? rdata_q : alu_q (combinational from registers). WriteReg = dest_q. wb_valid = valid_q.
- RegWrite_wb = valid_q & new_q & regwrite_q & (dest_q != 0). $0 is never written. A stalled entry writes exactly once, in its first cycle.
- Bypass: each edge, prev_RegWrite←RegWrite_wb, prev_WriteReg←WriteReg, prev_WriteData←WriteData. Flush and stall do not affect the bypass update.
- retired_count increments by 1 on every edge that performs a load with mem_valid=1. It wraps modulo 2^CNT_WIDTH from all-ones to 0.
- Entry state per instruction: EMPTY (valid_q=0) → FRESH (valid_q=1,new_q=1) → HELD (valid_q=1,new_q=0, only via stall). Exits: load → EMPTY or FRESH; flush → EMPTY.

## Timing
- Reset (async, rst_n=0): every register and output is 0, including wb_valid, WriteReg, WriteData, RegWrite_wb, prev_* and retired_count. Reset takes effect immediately, mid-operation, without a clock. The first load happens on the first rising edge with rst_n=1.
- Latency: MEM inputs at edge N appear on WriteReg/WriteData/RegWrite_wb after edge N, i.e. in cycle N+1. Bypass outputs follow one cycle later, in cycle N+2.
- Throughput: one instruction per cycle when stall=0.
- Simultaneous stall and flush: flush wins and the entry is discarded.
- Load with mem_valid=0: bubble. The counter does not increment.
- No combinational path from any input to any output; all outputs depend only on registers.

## Test plan
- Reset: drive rst_n=0 mid-stream with valid data loaded → all outputs 0 immediately. Release rst_n, load ALUResult=5, dest=3, RegWrite=1, MemtoReg=0 → next cycle WriteData=5, WriteReg=3, RegWrite_wb=1, retired_count=1.
- Load path: ReadData=1111, ALUResult=1, MemtoReg=1, dest=8 → WriteData=1111, RegWrite_wb=1. The following cycle prev_RegWrite=1, prev_WriteReg=8, prev_WriteData=1111.
- $0 suppression: dest=0, RegWrite=1, ALUResult=100 → wb_valid=1, RegWrite_wb=0, retired_count increments.
- Stall hold: load dest=4, data=7, then stall=1 for 3 cycles → RegWrite_wb=1 in the first cycle only, WriteData stays 7, retired_count increments once.
- Flush priority: stall=1 and flush=1 on the same edge with a valid entry → wb_valid=0, RegWrite_wb=0, counter unchanged.
- Counter wrap: with CNT_WIDTH=4, load 17 valid instructions → retired_count=1.
